ram_master: RTL and testbench
=============================

Name: ram_master

Overview:
- Bus master that drives the single-port RAM's shared tristate data bus on behalf of a requester.
- Accepts read and write requests through a valid/ready handshake.
- Sequences the RAM's `clk`/`isReading`/`address`/`data` pins so that no spurious writes and no bus contention ever occur.
- Returns read data on a one-cycle response pulse. Sits between the CPU datapath and the RAM instance.

Parameters:
- ADDRESS_SIZE, 11, RAM address width.
- MEM_WORD_SIZE, 63, RAM word width.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present; requester holds it and all req_* stable until accepted
- req_ready  output  1  high when a request can be accepted
- req_write  input  1  1 = write, 0 = read
- req_address  input  ADDRESS_SIZE  target word address
- req_wdata  input  MEM_WORD_SIZE  write data
- resp_valid  output  1  one-cycle pulse: resp_rdata holds read result
- resp_rdata  output  MEM_WORD_SIZE  read data; holds its value until the next read response
- ram_address  output  ADDRESS_SIZE  to RAM address
- ram_isReading  output  1  to RAM isReading
- ram_data  inout  MEM_WORD_SIZE  to RAM data bus

Behaviour:
- RAM contract this block relies on:
  - At every rising clk edge, the RAM writes ram_data into mem[ram_address] if ram_isReading=0.
  - Otherwise it latches mem[ram_address] into its output register.
  - The RAM drives ram_data whenever ram_isReading=1.
- FSM states: IDLE, WRITE, RD_ADDR, RD_DATA. All outputs are registered, except the ram_data tristate driver, which is combinational from the drive-enable.
- Acceptance: a request is accepted on a rising edge with req_valid && req_ready. req_ready = (state==IDLE).
- IDLE:
  - ram_isReading=1, ram_data released (Z), ram_address holds its last value.
  - On accept: latch req_address into ram_address.
    - Write: latch req_wdata and go to WRITE.
    - Read: go to RD_ADDR.
- WRITE, one cycle:
  - ram_isReading=0, ram_data driven with the latched wdata.
  - RAM commits at the closing edge; the FSM returns to IDLE on that edge.
  - Issue interval is 2 cycles. No response pulse for writes.
- RD_ADDR, one cycle:
  - ram_isReading=1, bus released.
  - RAM latches the word at the closing edge; go to RD_DATA.
- RD_DATA, one cycle:
  - Bus carries the RAM word.
  - At the closing edge, capture ram_data into resp_rdata, set resp_valid=1, go to IDLE.
- Read latency: accept at edge E0; resp_valid high in the cycle after E2; issue interval is 3 cycles.
- Response may coincide with a new accept: resp_valid is high in IDLE while req_ready is high.
- resp_valid is cleared on the next edge. There is no response backpressure.
- Invariants (bench assertions):
  - ram_isReading=0 only in WRITE.
  - ram_data is driven by this block only in WRITE.
  - ram_isReading never changes except at a clk edge or on reset.
- Write→read back-to-back to the same address returns the new data, because the commit at E1 precedes the read latch.
- Address range: 0..2^ADDRESS_SIZE-1. There is no wrap arithmetic; addresses pass through unchanged.
- Reset (asserted immediately and asynchronously):
  - State IDLE, ram_isReading=1, drive-enable=0 (bus Z), ram_address=0, wdata reg=0, resp_valid=0, resp_rdata=0.
  - Reset during WRITE aborts the write: isReading rises before the next edge, so the RAM contents are unchanged.
  - Reset during RD_ADDR/RD_DATA drops the response; no resp_valid pulse.
  - req_ready is 0 while reset is high.

Test Plan:
- Write 63'h155 to addr 5 → exactly one cycle with ram_isReading=0, bus=63'h155. Then read addr 5 → resp_valid pulses in the 3rd cycle after accept, resp_rdata=63'h155.
- Read unwritten addr 100 after power-up → resp_rdata=0, resp_valid high for exactly 1 cycle.
- Back-to-back: write 63'h7FFF_FFFF_FFFF_FFFF to addr 2047, then a read of 2047 presented immediately → accepted the cycle after the write; returns the same value. A second read is accepted in the same cycle resp_valid is high.
- Idle for 50 cycles with req_valid=0 → ram_isReading stays 1, bus never driven, RAM contents unchanged (mem[5] still 63'h155).
- Assert reset mid-WRITE (data 63'h1 to addr 7) → ram_isReading=1 before the next edge. A later read of addr 7 returns 0.
- Assert reset in RD_DATA → no resp_valid; after release, req_ready=1 and ram_address=0.

Source files
------------

// File: rtl/ram_master.sv
// rtl/ram_master.sv - bus master sequencing a single-port RAM over a shared tristate data bus
// Requests arrive on a valid/ready handshake; read results return on a one-cycle pulse.
module ram_master #(
    parameter int ADDRESS_SIZE  = 11,
    parameter int MEM_WORD_SIZE = 63
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_SIZE-1:0]  req_address,
    input  logic [MEM_WORD_SIZE-1:0] req_wdata,
    output logic                     resp_valid,
    output logic [MEM_WORD_SIZE-1:0] resp_rdata,
    output logic [ADDRESS_SIZE-1:0]  ram_address,
    output logic                     ram_isReading,
    inout  wire  [MEM_WORD_SIZE-1:0] ram_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     w_accept;
    logic [ADDRESS_SIZE-1:0]  r_address;
    logic [MEM_WORD_SIZE-1:0] r_wdata;
    logic                     r_is_reading;
    logic                     r_drive;
    logic                     r_resp_valid;
    logic [MEM_WORD_SIZE-1:0] r_resp_rdata;

    // Gated by reset so no request can be handed over while the block is held.
    assign req_ready = (r_state == IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = req_write ? WRITE : RD_ADDR;
                end
            end
            WRITE:   w_next_state = IDLE;
            RD_ADDR: w_next_state = RD_DATA;
            RD_DATA: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Pin controls are decoded from the next state so they switch exactly at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_address    <= '0;
            r_wdata      <= '0;
            r_is_reading <= 1'b1;
            r_drive      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_is_reading <= (w_next_state != WRITE);
            r_drive      <= (w_next_state == WRITE);
            r_resp_valid <= (r_state == RD_DATA);
            if (w_accept) begin
                r_address <= req_address;
                if (req_write) begin
                    r_wdata <= req_wdata;
                end
            end
            if (r_state == RD_DATA) begin
                r_resp_rdata <= ram_data;
            end
        end
    end

    assign ram_data      = r_drive ? r_wdata : {MEM_WORD_SIZE{1'bz}};
    assign ram_address   = r_address;
    assign ram_isReading = r_is_reading;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;

endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - directed self-checking bench for ram_master with a behavioural RAM
// The RAM model follows the write-on-low-isReading / latch-on-high contract.
`timescale 1ns/1ps
module tb_ram_master;

    localparam int AW = 11;
    localparam int DW = 63;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_address;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic [AW-1:0] ram_address;
    logic          ram_isReading;
    wire  [DW-1:0] ram_data;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;

    int  n_cmp;
    int  n_fail;
    int  cyc;
    time t_pos;

    ram_master #(.ADDRESS_SIZE(AW), .MEM_WORD_SIZE(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_address  (req_address),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .ram_address  (ram_address),
        .ram_isReading(ram_isReading),
        .ram_data     (ram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!ram_isReading) mem[ram_address] <= ram_data;
        else                ram_q <= mem[ram_address];
    end
    assign ram_data = ram_isReading ? ram_q : {DW{1'bz}};

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) t_pos = $time;

    // Bus contention or a floating bus shows up as X/Z on the shared data lines.
    always @(negedge clk) begin
        n_cmp++;
        if (^ram_data === 1'bx) begin
            n_fail++;
            $display("FAIL bus_contention: ram_data=%h isReading=%b required fully driven", ram_data, ram_isReading);
        end
    end

    always @(ram_isReading) begin
        if (!reset && $time != 0) begin
            n_cmp++;
            if ($time != t_pos) begin
                n_fail++;
                $display("FAIL isreading_glitch: changed at %0t, last edge %0t, required equal", $time, t_pos);
            end
        end
    end

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc);
        int w;
        req_write   = wr;
        req_address = a;
        req_wdata   = d;
        req_valid   = 1'b1;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (w >= 20) begin
            n_fail++;
            $display("FAIL issue_timeout: req_ready=%b required 1", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_wdata = '0;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (ram_isReading !== 1'b1) begin n_fail++; $display("FAIL rst_isreading: got %b required 1", ram_isReading); end
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b required 0", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b required 0", resp_valid); end
        n_cmp++; if (resp_rdata !== '0) begin n_fail++; $display("FAIL rst_rdata: got %h required 0", resp_rdata); end
        n_cmp++; if (ram_address !== '0) begin n_fail++; $display("FAIL rst_address: got %0d required 0", ram_address); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_read_unwritten();
        int acc;
        int pulses;
        pulses = 0;
        issue(1'b0, 11'd100, '0, acc);
        n_cmp++; if (ram_address !== 11'd100) begin n_fail++; $display("FAIL rd100_address: got %0d required 100", ram_address); end
        for (int i = 0; i < 6; i++) begin
            if (resp_valid === 1'b1) begin
                pulses++;
                n_cmp++; if (resp_rdata !== '0) begin n_fail++; $display("FAIL rd100_data: got %h required 0", resp_rdata); end
            end
            @(negedge clk);
        end
        n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL rd100_pulses: got %0d required 1", pulses); end
    endtask

    task automatic test_write_read();
        int acc;
        issue(1'b1, 11'd5, 63'h155, acc);
        n_cmp++; if (ram_isReading !== 1'b0) begin n_fail++; $display("FAIL wr5_isreading: got %b required 0", ram_isReading); end
        n_cmp++; if (ram_data !== 63'h155) begin n_fail++; $display("FAIL wr5_bus: got %h required 155", ram_data); end
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL wr5_ready_busy: got %b required 0", req_ready); end
        @(negedge clk);
        n_cmp++; if (ram_isReading !== 1'b1) begin n_fail++; $display("FAIL wr5_one_cycle: got %b required 1", ram_isReading); end
        n_cmp++; if (mem[5] !== 63'h155) begin n_fail++; $display("FAIL wr5_commit: got %h required 155", mem[5]); end
        issue(1'b0, 11'd5, '0, acc);
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd5_c1_valid: got %b required 0", resp_valid); end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd5_c2_valid: got %b required 0", resp_valid); end
        n_cmp++; if (ram_data !== 63'h155) begin n_fail++; $display("FAIL rd5_bus: got %h required 155", ram_data); end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL rd5_c3_valid: got %b required 1", resp_valid); end
        n_cmp++; if (resp_rdata !== 63'h155) begin n_fail++; $display("FAIL rd5_data: got %h required 155", resp_rdata); end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd5_c4_valid: got %b required 0", resp_valid); end
        n_cmp++; if (resp_rdata !== 63'h155) begin n_fail++; $display("FAIL rd5_hold: got %h required 155", resp_rdata); end
    endtask

    task automatic test_back_to_back();
        int acc_w;
        int acc_r;
        int acc_r2;
        logic [DW-1:0] ones;
        ones = {DW{1'b1}};
        issue(1'b1, 11'd2047, ones, acc_w);
        n_cmp++; if (ram_data !== ones) begin n_fail++; $display("FAIL b2b_wbus: got %h required %h", ram_data, ones); end
        issue(1'b0, 11'd2047, '0, acc_r);
        n_cmp++; if (acc_r - acc_w != 2) begin n_fail++; $display("FAIL b2b_issue_gap: got %0d required 2", acc_r - acc_w); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b required 1", resp_valid); end
        n_cmp++; if (resp_rdata !== ones) begin n_fail++; $display("FAIL b2b_data: got %h required %h", resp_rdata, ones); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_with_resp: got %b required 1", req_ready); end
        issue(1'b0, 11'd2047, '0, acc_r2);
        n_cmp++; if (acc_r2 - acc_r != 3) begin n_fail++; $display("FAIL b2b_read_gap: got %0d required 3", acc_r2 - acc_r); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== ones) begin n_fail++; $display("FAIL b2b_second: valid=%b data=%h required 1/%h", resp_valid, resp_rdata, ones); end
    endtask

    task automatic test_idle();
        int writes;
        int bad_bus;
        int acc;
        writes = 0;
        bad_bus = 0;
        req_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ram_isReading !== 1'b1) writes++;
            if (ram_data !== ram_q) bad_bus++;
        end
        n_cmp++; if (writes != 0) begin n_fail++; $display("FAIL idle_isreading: got %0d write cycles required 0", writes); end
        n_cmp++; if (bad_bus != 0) begin n_fail++; $display("FAIL idle_bus: got %0d driven cycles required 0", bad_bus); end
        issue(1'b0, 11'd5, '0, acc);
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== 63'h155) begin n_fail++; $display("FAIL idle_mem5: valid=%b data=%h required 1/155", resp_valid, resp_rdata); end
    endtask

    task automatic test_reset_mid_write();
        int acc;
        issue(1'b1, 11'd7, 63'h1, acc);
        reset = 1'b1;
        #1;
        n_cmp++; if (ram_isReading !== 1'b1) begin n_fail++; $display("FAIL rstw_isreading: got %b required 1", ram_isReading); end
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rstw_ready: got %b required 0", req_ready); end
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (mem[7] !== '0) begin n_fail++; $display("FAIL rstw_mem7: got %h required 0", mem[7]); end
        @(negedge clk);
        issue(1'b0, 11'd7, '0, acc);
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== '0) begin n_fail++; $display("FAIL rstw_read7: valid=%b data=%h required 1/0", resp_valid, resp_rdata); end
    endtask

    task automatic test_reset_in_rd_data();
        int acc;
        int pulses;
        pulses = 0;
        issue(1'b0, 11'd5, '0, acc);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (ram_address !== '0) begin n_fail++; $display("FAIL rstr_address: got %0d required 0", ram_address); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL rstr_no_resp: got %0d pulses required 0", pulses); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstr_ready: got %b required 1", req_ready); end
        n_cmp++; if (ram_address !== '0) begin n_fail++; $display("FAIL rstr_address_after: got %0d required 0", ram_address); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        cyc = 0;
        t_pos = 0;
        ram_q = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        test_reset();
        test_read_unwritten();
        test_write_read();
        test_back_to_back();
        test_idle();
        test_reset_mid_write();
        test_reset_in_rd_data();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
